// File: rtl/serial_link_physical_rx_os.sv
// serial_link_physical_rx_os: oversampling receive PHY for the serial link.
// The forwarded clock and data lanes are synchronized into clk_i, forwarded-
// clock edges are detected, DDR/SDR half-words are reassembled into words and
// buffered in a small valid/ready FIFO.
// Optional feature macro: SERIAL_LINK_RX_OS_OVF_CNT_EN (16-bit saturating
// dropped-word counter on ovf_cnt_o; tied to zero when undefined).
module serial_link_physical_rx_os #(
    parameter int unsigned NumLanes   = 8,
    parameter int unsigned FifoDepth  = 4,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned IdleCycles = 16,
    parameter bit          EnDdr      = 1'b1,
    localparam int unsigned WordW     = EnDdr ? 2 * NumLanes : NumLanes
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rcv_clk_i,
    input  logic [NumLanes-1:0] ddr_i,
    output logic [WordW-1:0]    data_in_o,
    output logic                data_in_valid_o,
    input  logic                data_in_ready_i,
    output logic                overflow_o,
    output logic [15:0]         ovf_cnt_o
);

    localparam int unsigned AddrW = $clog2(FifoDepth);
    localparam int unsigned PtrW  = AddrW + 1;

    typedef logic [WordW-1:0] phy_data_t;

    logic [SyncStages-1:0]               rclk_sync_q;
    logic [SyncStages-1:0][NumLanes-1:0] lane_sync_q;
    logic                                rclk_q;
    logic                                rclk_s;
    logic [NumLanes-1:0]                 lane_s;
    logic                                rise;

    logic      asm_valid;
    phy_data_t asm_data;

    phy_data_t        mem_q [FifoDepth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    phy_data_t        head_q, head_d;
    logic             valid_q;
    logic             overflow_q;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    // Identical synchronizer chains keep clock and lanes aligned, plus one
    // extra flop on the clock for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rclk_sync_q <= '0;
            lane_sync_q <= '0;
            rclk_q      <= 1'b0;
        end else begin
            rclk_sync_q <= {rclk_sync_q[SyncStages-2:0], rcv_clk_i};
            lane_sync_q <= {lane_sync_q[SyncStages-2:0], ddr_i};
            rclk_q      <= rclk_sync_q[SyncStages-1];
        end
    end

    assign rclk_s = rclk_sync_q[SyncStages-1];
    assign lane_s = lane_sync_q[SyncStages-1];
    assign rise   = rclk_s & ~rclk_q;

    if (EnDdr) begin : g_ddr
        localparam int unsigned IdleW = $clog2(IdleCycles + 1);

        typedef enum logic {
            LOW_WAIT  = 1'b0,
            HIGH_WAIT = 1'b1
        } state_e;

        state_e              state_q;
        state_e              state_eff;
        logic [NumLanes-1:0] low_q;
        logic [IdleW-1:0]    idle_cnt_q;
        logic                fall;
        logic                idle_hit;

        assign fall     = ~rclk_s & rclk_q;
        assign idle_hit = (idle_cnt_q == IdleW'(IdleCycles));
        // A timed-out link behaves as if the FSM were already back in LOW_WAIT.
        assign state_eff = idle_hit ? LOW_WAIT : state_q;

        // Idle counter: cleared by any edge, saturates at IdleCycles.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                idle_cnt_q <= '0;
            end else if (rise | fall) begin
                idle_cnt_q <= '0;
            end else if (!idle_hit) begin
                idle_cnt_q <= idle_cnt_q + IdleW'(1);
            end
        end

        // Half-word assembly FSM: low half on the fall, word completes on the rise.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= LOW_WAIT;
                low_q   <= '0;
            end else begin
                case (state_eff)
                    LOW_WAIT: begin
                        if (fall) begin
                            low_q   <= lane_s;
                            state_q <= HIGH_WAIT;
                        end else if (idle_hit) begin
                            low_q   <= '0;
                            state_q <= LOW_WAIT;
                        end
                    end
                    HIGH_WAIT: begin
                        if (rise) begin
                            state_q <= LOW_WAIT;
                        end
                    end
                    default: state_q <= LOW_WAIT;
                endcase
            end
        end

        assign asm_valid = rise & (state_eff == HIGH_WAIT);
        assign asm_data  = {lane_s, low_q};
    end else begin : g_sdr
        assign asm_valid = rise;
        assign asm_data  = lane_s;
    end

    // FIFO control: a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        full = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
               (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        pop      = valid_q & data_in_ready_i;
        push     = asm_valid & (~full | pop);
        drop     = asm_valid & full & ~pop;
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        head_d   = mem_q[rd_ptr_d[AddrW-1:0]];
        if (push && (wr_ptr_q[AddrW-1:0] == rd_ptr_d[AddrW-1:0])) begin
            head_d = asm_data;
        end
    end

    // FIFO storage, written only on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= asm_data;
        end
    end

    // Pointers, registered head word/valid and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            head_q     <= head_d;
            valid_q    <= (wr_ptr_d != rd_ptr_d);
            overflow_q <= overflow_q | drop;
        end
    end

    assign data_in_o       = head_q;
    assign data_in_valid_o = valid_q;
    assign overflow_o      = overflow_q;

`ifdef SERIAL_LINK_RX_OS_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    // Saturating count of dropped words.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = '0;
`endif

endmodule
